// File: rtl/shift_sequencer.sv
// Multi-cycle variable shifter: walks the set bits of the shift amount from the
// highest down, applying one fixed power-of-two SLL/SRA stage per cycle.
module shift_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               op_q, op_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] stage_mask;
  logic [WIDTH-1:0]   stage_res;
  logic [SHAMT_W-1:0] rem_after;

  // Pick the highest pending stage and form its fixed-distance shift of result
  always_comb begin
    stage_mask = '0;
    stage_res  = result_q;
    if (rem_q[4]) begin
      stage_mask = SHAMT_W'(16);
      stage_res  = op_q ? WIDTH'($signed(result_q) >>> 16) : (result_q << 16);
    end else if (rem_q[3]) begin
      stage_mask = SHAMT_W'(8);
      stage_res  = op_q ? WIDTH'($signed(result_q) >>> 8) : (result_q << 8);
    end else if (rem_q[2]) begin
      stage_mask = SHAMT_W'(4);
      stage_res  = op_q ? WIDTH'($signed(result_q) >>> 4) : (result_q << 4);
    end else if (rem_q[1]) begin
      stage_mask = SHAMT_W'(2);
      stage_res  = op_q ? WIDTH'($signed(result_q) >>> 2) : (result_q << 2);
    end else if (rem_q[0]) begin
      stage_mask = SHAMT_W'(1);
      stage_res  = op_q ? WIDTH'($signed(result_q) >>> 1) : (result_q << 1);
    end
    rem_after = rem_q & ~stage_mask;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          result_d = data_in;
          rem_d    = shamt;
          op_d     = op;
          state_d  = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        result_d = stage_res;
        rem_d    = rem_after;
        state_d  = (rem_after == '0) ? DONE : SHIFT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so busy/done come straight from flops
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, result, busy/done and reset cases.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op, wait for done, check latency, busy while waiting, result,
  // then check the cycle after done is quiet and result holds.
  task automatic run_op(input string tag, input logic o, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_res,
                        input int exp_lat);
    int n;
    start = 1'b1; op = o; data_in = d; shamt = s;
    tick();
    start = 1'b0; op = ~o; data_in = ~d; shamt = ~s;
    n = 1;
    while (!done && n < 20) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_res"}, result, exp_res);
    tick();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = 1'b0; data_in = '0; shamt = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", result, 32'd0);
    reset = 1'b0;
    tick();

    // Basic vectors
    run_op("t1_sra4",   1'b1, 32'h8000_0000, 5'd4,  32'hF800_0000, 2);
    run_op("t2_sra31",  1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6);
    run_op("t3_sll20",  1'b0, 32'h0000_0001, 5'd20, 32'h0010_0000, 3);
    run_op("t3_sra20",  1'b1, 32'h7FFF_FFF0, 5'd20, 32'h0000_07FF, 3);
    run_op("t4_sll0",   1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
    run_op("t4_sra0",   1'b1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
    run_op("x_sll7",    1'b0, 32'h1234_5678, 5'd7,  32'h1A2B_3C00, 4);
    run_op("x_sra1",    1'b1, 32'h8000_0001, 5'd1,  32'hC000_0000, 2);
    run_op("x_sll31",   1'b0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 6);
    run_op("x_sra9pos", 1'b1, 32'h4000_0000, 5'd9,  32'h0020_0000, 3);

    // Start while busy is ignored; exactly one done pulse
    start = 1'b1; op = 1'b1; data_in = 32'hF000_0000; shamt = 5'd3;
    tick();                                   // C+1
    op = 1'b0; data_in = 32'h1; shamt = 5'd1; // start still high in C+1
    tick();                                   // C+2
    start = 1'b0;
    check("t5_notdone_c2", 32'(done), 32'd0);
    tick();                                   // C+3
    check("t5_done_c3", 32'(done), 32'd1);
    check("t5_res", result, 32'hFE00_0000);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    check("t5_single_done", 32'(dones), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_hold", result, 32'hFE00_0000);

    // Reset mid-operation abandons the op
    start = 1'b1; op = 1'b0; data_in = 32'hFFFF_FFFF; shamt = 5'd31;
    tick();                                   // C+1
    start = 1'b0;
    tick();                                   // C+2
    reset = 1'b1;
    tick();                                   // C+3
    reset = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_res", result, 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) dones++;
    end
    check("t6_no_done", 32'(dones), 32'd0);
    run_op("t6_after", 1'b1, 32'h8000_0000, 5'd4, 32'hF800_0000, 2);

    // Reset and start together: reset wins
    reset = 1'b1; start = 1'b1; op = 1'b0; data_in = 32'h5; shamt = 5'd2;
    tick();
    reset = 1'b0; start = 1'b0;
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_res", result, 32'd0);
    tick();
    check("rs_busy2", 32'(busy), 32'd0);
    check("rs_done2", 32'(done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
